// File: rtl/dmem_responder.sv
// Data-memory slave: word-organised RAM with byte/half/word access plus a small IO window
// (GPIO out, synchronised GPIO in, cycle counter). Responses arrive one cycle after the request.
package dmem_pkg;
    typedef enum logic [3:0] {
        LOAD_STORE_NONE    = 4'd0,
        LOAD_WORD          = 4'd1,
        LOAD_HALF          = 4'd2,
        LOAD_BYTE          = 4'd3,
        LOAD_HALF_UNSIGNED = 4'd4,
        LOAD_BYTE_UNSIGNED = 4'd5,
        STORE_WORD         = 4'd6,
        STORE_HALF         = 4'd7,
        STORE_BYTE         = 4'd8
    } mem_op_t;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  mem_op_t     dmem_op,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic [1:0] {
        IO_GPIO_OUT = 2'd0,
        IO_GPIO_IN  = 2'd1,
        IO_CYCLE    = 2'd2,
        IO_RSVD     = 2'd3
    } io_reg_e;

    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_ram_q;
    logic [31:0] r_io_q;
    logic        r_is_ram;
    mem_op_t     r_op;
    logic [1:0]  r_lane;
    logic        r_err;
    logic [31:0] r_cycle;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [15:0] r_gpio_out;

    logic          w_is_load;
    logic          w_is_store;
    logic          w_is_word;
    logic          w_is_half;
    logic          w_is_ram;
    logic          w_misaligned;
    logic          w_err;
    logic          w_ram_we;
    logic          w_gpio_we;
    io_reg_e       w_io_sel;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;
    logic [31:0]   w_io_rdata;
    logic [31:0]   w_cycle_next;
    logic [31:0]   w_word;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;

    assign w_cycle_next = r_cycle + 32'd1;
    assign w_idx        = dmem_addr[AW+1:2];
    assign gpio_out     = r_gpio_out;

    always_comb begin
        w_is_load    = dmem_op inside {LOAD_WORD, LOAD_HALF, LOAD_BYTE,
                                       LOAD_HALF_UNSIGNED, LOAD_BYTE_UNSIGNED};
        w_is_store   = dmem_op inside {STORE_WORD, STORE_HALF, STORE_BYTE};
        w_is_word    = dmem_op inside {LOAD_WORD, STORE_WORD};
        w_is_half    = dmem_op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF};
        w_is_ram     = (dmem_addr[31:12] == '0);
        w_io_sel     = io_reg_e'(dmem_addr[3:2]);
        w_misaligned = (w_is_word && (dmem_addr[1:0] != 2'b00)) ||
                       (w_is_half && dmem_addr[0]);
        w_err        = (w_is_load || w_is_store) &&
                       (w_misaligned ||
                        (w_is_ram && ({22'b0, dmem_addr[11:2]} >= RAM_WORDS)) ||
                        (!w_is_ram && !w_is_word) ||
                        (!w_is_ram && w_is_store && (w_io_sel != IO_GPIO_OUT)));
        w_ram_we     = resetn && w_is_store && w_is_ram && !w_err;
        w_gpio_we    = w_is_store && !w_is_ram && !w_err;

        // Narrow store data is replicated across lanes so each enabled lane picks its own copy
        unique case (dmem_op)
            STORE_BYTE: begin
                w_be    = 4'b0001 << dmem_addr[1:0];
                w_wlane = {4{dmem_wdata[7:0]}};
            end
            STORE_HALF: begin
                w_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{dmem_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = dmem_wdata;
            end
        endcase

        unique case (w_io_sel)
            IO_GPIO_OUT: w_io_rdata = {16'b0, r_gpio_out};
            IO_GPIO_IN:  w_io_rdata = {16'b0, r_sync2};
            IO_CYCLE:    w_io_rdata = r_cycle;
            default:     w_io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
        r_ram_q <= r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op       <= LOAD_STORE_NONE;
            r_lane     <= '0;
            r_err      <= 1'b0;
            r_is_ram   <= 1'b0;
            r_io_q     <= '0;
            r_cycle    <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_gpio_out <= '0;
        end else begin
            r_op     <= dmem_op;
            r_lane   <= dmem_addr[1:0];
            r_err    <= w_err;
            r_is_ram <= w_is_ram;
            r_io_q   <= w_io_rdata;
            r_cycle  <= w_cycle_next;
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            if (w_gpio_we) r_gpio_out <= dmem_wdata[15:0];
        end
    end

    // Lane extraction uses the captured op/lane, so live inputs in N+1 cannot disturb the result
    always_comb begin
        w_word = r_is_ram ? r_ram_q : r_io_q;
        w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];
        unique case (r_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase

        dmem_rdata = '0;
        if (!r_err) begin
            unique case (r_op)
                LOAD_WORD:          dmem_rdata = w_word;
                LOAD_HALF:          dmem_rdata = {{16{w_half[15]}}, w_half};
                LOAD_HALF_UNSIGNED: dmem_rdata = {16'b0, w_half};
                LOAD_BYTE:          dmem_rdata = {{24{w_byte[7]}}, w_byte};
                LOAD_BYTE_UNSIGNED: dmem_rdata = {24'b0, w_byte};
                default:            dmem_rdata = '0;
            endcase
        end
        dmem_error = r_err;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a
// byte-addressed reference model of RAM, GPIO and the cycle counter.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned RAM_WORDS = 512;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    mem_op_t     dmem_op = LOAD_STORE_NONE;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_error;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;

    always #5 clk = ~clk;

    dmem_responder #(.RAM_WORDS(RAM_WORDS), .INIT_FILE("")) dut (
        .clk        (clk),
        .resetn     (resetn),
        .dmem_op    (dmem_op),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_error (dmem_error),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out)
    );

    // Reference model state
    logic [7:0]  m_mem [4096];
    logic [15:0] m_gpio_out = '0;
    logic [15:0] m_s1 = '0;
    logic [15:0] m_s2 = '0;
    logic [31:0] m_cycle = '0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;

    int tests_run = 0;
    int failures  = 0;

    // Present one request for one cycle; afterwards exp_* hold the model's answer,
    // and the DUT outputs are sampled 1 time unit after the edge.
    task automatic step(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
        logic        load, store, err;
        int          size;
        logic [31:0] v;
        dmem_op    = op;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        load  = op inside {LOAD_WORD, LOAD_HALF, LOAD_BYTE, LOAD_HALF_UNSIGNED, LOAD_BYTE_UNSIGNED};
        store = op inside {STORE_WORD, STORE_HALF, STORE_BYTE};
        if (op inside {LOAD_WORD, STORE_WORD}) size = 4;
        else if (op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF}) size = 2;
        else size = 1;
        err = 1'b0;
        if (load || store) begin
            if ((addr % 32'(size)) != 0) err = 1'b1;
            if (addr < 32'h1000) begin
                if ((addr / 4) >= RAM_WORDS) err = 1'b1;
            end else begin
                if (size != 4) err = 1'b1;
                if (store && ((addr % 16) / 4) != 0) err = 1'b1;
            end
        end
        v = '0;
        if (load && !err) begin
            if (addr < 32'h1000) begin
                for (int i = size - 1; i >= 0; i--) v = (v << 8) | 32'(m_mem[int'(addr) + i]);
            end else begin
                case ((addr % 16) / 4)
                    0:       v = {16'b0, m_gpio_out};
                    1:       v = {16'b0, m_s2};
                    2:       v = m_cycle;
                    default: v = '0;
                endcase
            end
            if (op == LOAD_BYTE && v >= 32'h80)   v = v | 32'hFFFF_FF00;
            if (op == LOAD_HALF && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        @(posedge clk);
        if (!resetn) begin
            m_cycle = '0; m_s1 = '0; m_s2 = '0; m_gpio_out = '0;
            exp_rdata = '0; exp_err = 1'b0;
        end else begin
            if (store && !err) begin
                if (addr < 32'h1000) begin
                    for (int i = 0; i < size; i++) m_mem[int'(addr) + i] = wdata[8*i +: 8];
                end else begin
                    m_gpio_out = wdata[15:0];
                end
            end
            m_cycle   = m_cycle + 1;
            m_s2      = m_s1;
            m_s1      = gpio_in;
            exp_rdata = v;
            exp_err   = err;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(LOAD_STORE_NONE, '0, '0);
        step(LOAD_STORE_NONE, '0, '0);
        resetn = 1'b1;
        tests_run++;
        if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 00000000", dmem_rdata); end
        tests_run++;
        if (dmem_error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", dmem_error); end
        tests_run++;
        if (gpio_out !== 16'h0) begin failures++; $display("FAIL reset_gpio_out: got %h want 0000", gpio_out); end
    endtask

    task automatic test_loads();
        logic [31:0] want [5];
        mem_op_t     ops  [5];
        logic [31:0] adrs [5];
        want = '{32'hDEADBEEF, 32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF};
        ops  = '{LOAD_WORD, LOAD_BYTE, LOAD_BYTE_UNSIGNED, LOAD_HALF, LOAD_HALF_UNSIGNED};
        adrs = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h100};
        step(STORE_WORD, 32'h100, 32'hDEADBEEF);
        tests_run++;
        if (dmem_rdata !== 32'h0 || dmem_error !== 1'b0) begin
            failures++; $display("FAIL store_resp: got %h/%b want 00000000/0", dmem_rdata, dmem_error);
        end
        for (int k = 0; k < 5; k++) begin
            step(ops[k], adrs[k], $urandom);
            tests_run++;
            if (dmem_rdata !== want[k] || dmem_error !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d %s@%h: got %h/%b want %h/0", k, ops[k].name(), adrs[k], dmem_rdata, dmem_error, want[k]);
            end
        end
        step(LOAD_STORE_NONE, 32'h100, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL none_after_load: got %h want 00000000", dmem_rdata); end
    endtask

    task automatic test_merge();
        step(STORE_WORD, 32'h200, 32'h11223344);
        step(STORE_BYTE, 32'h201, 32'hFFFF_FFAA);
        step(STORE_HALF, 32'h202, 32'hFFFF_5566);
        step(LOAD_WORD,  32'h200, '0);
        tests_run++;
        if (dmem_rdata !== 32'h5566AA44) begin failures++; $display("FAIL lane_merge: got %h want 5566aa44", dmem_rdata); end
    endtask

    task automatic test_errors();
        mem_op_t     ops  [3];
        logic [31:0] adrs [3];
        ops  = '{LOAD_WORD, LOAD_HALF, STORE_WORD};
        adrs = '{32'h102, 32'h103, 32'h005};
        step(STORE_WORD, 32'h004, 32'h0BADF00D);
        for (int k = 0; k < 3; k++) begin
            step(ops[k], adrs[k], 32'hCAFEBABE);
            tests_run++;
            if (dmem_error !== 1'b1 || dmem_rdata !== 32'h0) begin
                failures++;
                $display("FAIL misalign_%0d @%h: got %h/%b want 00000000/1", k, adrs[k], dmem_rdata, dmem_error);
            end
        end
        step(LOAD_WORD, 32'h004, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0BADF00D || dmem_error !== 1'b0) begin
            failures++; $display("FAIL misalign_no_write: got %h/%b want 0badf00d/0", dmem_rdata, dmem_error);
        end
        step(LOAD_WORD, 32'h800, '0);
        tests_run++;
        if (dmem_error !== 1'b1 || dmem_rdata !== 32'h0) begin
            failures++; $display("FAIL ram_oob: got %h/%b want 00000000/1", dmem_rdata, dmem_error);
        end
    endtask

    task automatic test_gpio_out();
        step(STORE_WORD, 32'h1000, 32'h0001A5A5);
        tests_run++;
        if (gpio_out !== 16'hA5A5 || dmem_error !== 1'b0) begin
            failures++; $display("FAIL gpio_store: got %h/%b want a5a5/0", gpio_out, dmem_error);
        end
        step(LOAD_WORD, 32'h1000, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0000A5A5) begin failures++; $display("FAIL gpio_load: got %h want 0000a5a5", dmem_rdata); end
        step(STORE_BYTE, 32'h1000, 32'h0000_0011);
        tests_run++;
        if (dmem_error !== 1'b1 || gpio_out !== 16'hA5A5) begin
            failures++; $display("FAIL io_byte_store: got err=%b gpio=%h want 1/a5a5", dmem_error, gpio_out);
        end
        step(STORE_WORD, 32'h1004, 32'h0000_1234);
        tests_run++;
        if (dmem_error !== 1'b1 || dmem_rdata !== 32'h0) begin
            failures++; $display("FAIL io_ro_store: got %h/%b want 00000000/1", dmem_rdata, dmem_error);
        end
    endtask

    task automatic test_io_counter();
        logic [31:0] c1;
        gpio_in = 16'h3C3C;
        step(LOAD_STORE_NONE, '0, '0);
        step(LOAD_WORD, 32'h1004, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL gpio_sync_early: got %h want 00000000", dmem_rdata); end
        step(LOAD_WORD, 32'h1004, '0);
        tests_run++;
        if (dmem_rdata !== 32'h00003C3C) begin failures++; $display("FAIL gpio_sync: got %h want 00003c3c", dmem_rdata); end

        step(LOAD_WORD, 32'h1008, '0);
        c1 = dmem_rdata;
        tests_run++;
        if (dmem_rdata !== exp_rdata) begin failures++; $display("FAIL cycle_value: got %h want %h", dmem_rdata, exp_rdata); end
        for (int k = 0; k < 4; k++) step(LOAD_STORE_NONE, '0, '0);
        step(LOAD_WORD, 32'h1008, '0);
        tests_run++;
        if (dmem_rdata - c1 !== 32'd5) begin failures++; $display("FAIL cycle_delta: got %0d want 5", dmem_rdata - c1); end

        force dut.w_cycle_next = 32'hFFFF_FFFF;
        step(LOAD_STORE_NONE, '0, '0);
        release dut.w_cycle_next;
        m_cycle = 32'hFFFF_FFFF;
        step(LOAD_WORD, 32'h1008, '0);
        tests_run++;
        if (dmem_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_max: got %h want ffffffff", dmem_rdata); end
        step(LOAD_WORD, 32'h1008, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap: got %h want 00000000", dmem_rdata); end
    endtask

    task automatic test_random();
        mem_op_t     op;
        logic [31:0] addr;
        int          sel;
        for (int w = 0; w < 16; w++) step(STORE_WORD, 32'h300 + 32'(4 * w), $urandom);
        for (int n = 0; n < 200; n++) begin
            op  = mem_op_t'($urandom_range(0, 8));
            sel = $urandom_range(0, 99);
            if (sel < 70)      addr = 32'h300 + $urandom_range(0, 63);
            else if (sel < 85) addr = 32'h1000 + $urandom_range(0, 15);
            else               addr = 32'h800 + $urandom_range(0, 32'h7FF);
            if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
            step(op, addr, $urandom);
            tests_run++;
            if (dmem_rdata !== exp_rdata || dmem_error !== exp_err || gpio_out !== m_gpio_out) begin
                failures++;
                $display("FAIL random_%0d %s@%h: got %h/%b/%h want %h/%b/%h", n, op.name(), addr,
                         dmem_rdata, dmem_error, gpio_out, exp_rdata, exp_err, m_gpio_out);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        step(STORE_WORD, 32'h1000, 32'h0000BEEF);
        step(LOAD_WORD, 32'h100, '0);
        resetn = 1'b0;
        step(STORE_WORD, 32'h100, 32'h12345678);
        resetn = 1'b1;
        tests_run++;
        if (dmem_rdata !== 32'h0 || dmem_error !== 1'b0 || gpio_out !== 16'h0) begin
            failures++; $display("FAIL reset_flight: got %h/%b/%h want 00000000/0/0000", dmem_rdata, dmem_error, gpio_out);
        end
        step(LOAD_WORD, 32'h1008, '0);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle: got %h want 00000000", dmem_rdata); end
        step(LOAD_WORD, 32'h100, '0);
        tests_run++;
        if (dmem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL reset_no_store: got %h want deadbeef", dmem_rdata); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_loads();
        test_merge();
        test_errors();
        test_gpio_out();
        test_io_counter();
        test_random();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
